tinyalu_cmd_sequencer: RTL and testbench

//   Upstream command stage for tinyalu. Buffers ALU commands from a valid/ready source
//   in a small FIFO and issues them one at a time using the tinyalu start/done protocol.

---
 rtl/tinyalu_cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_tinyalu_cmd_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_cmd_sequencer.sv
// Command stage in front of tinyalu: FIFO-buffers valid/ready commands, issues them one at a
// time with start/done, and returns result, tag and timeout error on a valid/ready response port.
//
// state | meaning
// IDLE  | waiting for a FIFO entry; pops head, drops NOPs, loads alu_* for real ops
// ISSUE | alu_start high, operands held, counting towards the done-timeout
// RESP  | response presented until accepted; alu_start low
module tinyalu_cmd_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             alu_start,
  output logic [2:0]       alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic             alu_done,
  input  logic [15:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic [2:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state, state_nxt;
  cmd_t             mem [FIFO_DEPTH];
  cmd_t             head;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, pop, load, timeout;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [TAG_W-1:0] tag_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign push    = cmd_valid && cmd_ready;
  assign pop     = (state == IDLE) && !empty;
  assign load    = pop && (head.op != 3'd0);
  assign cnt_nxt = cnt + 1'b1;
  assign timeout = (cnt_nxt == CW'(TIMEOUT_CYC));

  assign cmd_ready = !full && !rst;
  assign alu_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || !empty;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = ISSUE;
      ISSUE:   if (alu_done || timeout) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      tag_q      <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (load) begin
            alu_op <= head.op;
            alu_a  <= head.a;
            alu_b  <= head.b;
            tag_q  <= head.tag;
          end
        end
        ISSUE: begin
          cnt <= cnt_nxt;
          // A done in the same cycle as the timeout still counts as success.
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            rsp_tag    <= tag_q;
          end else if (timeout) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_tag    <= tag_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_cmd_sequencer.sv
// Directed bench for tinyalu_cmd_sequencer: the bench plays both the command source and
// the tinyalu, and checks every observation against hand-computed values.
module tb_tinyalu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_rsp    = 0;
  int starts0, rsp0, hi;
  logic start_d = 1'b0;

  tinyalu_cmd_sequencer #(.FIFO_DEPTH(4), .TAG_W(4), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event counters: rising edges of alu_start and accepted responses.
  always @(posedge clk) begin
    start_d <= alu_start;
    if (alu_start && !start_d) n_starts <= n_starts + 1;
    if (!rst && rsp_valid && rsp_ready) n_rsp <= n_rsp + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    #1;
    chk("cmd_ready_on_push", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (alu_start) break;
      tick();
    end
    chk("start_seen", 32'(alu_start), 32'd1);
  endtask

  // Hold done low for wait_cyc start cycles, then assert done with res for one cycle.
  task automatic do_alu(input int wait_cyc, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] res);
    for (int i = 0; i <= wait_cyc; i++) begin
      chk("alu_start_held", 32'(alu_start), 32'd1);
      chk("alu_op", 32'(alu_op), 32'(op));
      chk("alu_a", 32'(alu_a), 32'(a));
      chk("alu_b", 32'(alu_b), 32'(b));
      if (i == wait_cyc) begin
        alu_done = 1'b1; alu_result = res;
      end
      tick();
    end
    alu_done = 1'b0; alu_result = 16'hDEAD;
  endtask

  task automatic expect_rsp(input logic [15:0] res, input logic [3:0] tag, input logic err);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_result", 32'(rsp_result), 32'(res));
    chk("rsp_tag", 32'(rsp_tag), 32'(tag));
    chk("rsp_err", 32'(rsp_err), 32'(err));
    chk("alu_start_low_in_resp", 32'(alu_start), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    alu_done = 1'b0; alu_result = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    rst = 1'b0;
    #1;
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // 1: ADD FF+01, exact N+2 start latency, done one cycle after start
    push(3'd1, 8'hFF, 8'h01, 4'd3);
    chk("t1_no_start_n1", 32'(alu_start), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_start_n2", 32'(alu_start), 32'd1);
    do_alu(1, 3'd1, 8'hFF, 8'h01, 16'h0100);
    expect_rsp(16'h0100, 4'd3, 1'b0);
    tick();
    expect_rsp(16'h0100, 4'd3, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: MUL FF*FF, start held for three cycles
    push(3'd4, 8'hFF, 8'hFF, 4'd9);
    wait_start(4);
    do_alu(2, 3'd4, 8'hFF, 8'hFF, 16'hFE01);
    expect_rsp(16'hFE01, 4'd9, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 3: backpressure, five back-to-back commands fill the FIFO behind the first
    for (int k = 0; k < 5; k++) push(3'd1, 8'(8'h10 + k), 8'(8'h20 + k), 4'(4 + k));
    chk("t3_full", 32'(cmd_ready), 32'd0);
    do_alu(0, 3'd1, 8'h10, 8'h20, 16'h0030);
    for (int i = 0; i < 20; i++) begin
      expect_rsp(16'h0030, 4'd4, 1'b0);
      chk("t3_still_full", 32'(cmd_ready), 32'd0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      expect_rsp(16'(16'h0030 + 2 * k), 4'(4 + k), 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      if (k < 4) begin
        wait_start(4);
        do_alu(0, 3'd1, 8'(8'h11 + k), 8'(8'h21 + k), 16'(16'h0032 + 2 * k));
      end
    end
    chk("t3_drained", 32'(busy), 32'd0);

    // 4: NOP between ADD and XOR yields exactly two starts and two responses
    starts0 = n_starts; rsp0 = n_rsp;
    rsp_ready = 1'b1;
    push(3'd1, 8'h05, 8'h06, 4'd1);
    push(3'd0, 8'h77, 8'h77, 4'd15);
    push(3'd3, 8'hF0, 8'h3C, 4'd2);
    wait_start(4);
    do_alu(0, 3'd1, 8'h05, 8'h06, 16'h000B);
    expect_rsp(16'h000B, 4'd1, 1'b0);
    tick();
    wait_start(6);
    do_alu(0, 3'd3, 8'hF0, 8'h3C, 16'h00CC);
    expect_rsp(16'h00CC, 4'd2, 1'b0);
    tick();
    tick(); tick();
    chk("t4_starts", 32'(n_starts - starts0), 32'd2);
    chk("t4_responses", 32'(n_rsp - rsp0), 32'd2);
    chk("t4_idle", 32'(busy), 32'd0);
    rsp_ready = 1'b0;

    // 5: timeout after 15 start cycles; late done ignored
    push(3'd2, 8'h0F, 8'h33, 4'd5);
    wait_start(4);
    hi = 0;
    while (alu_start && hi < 40) begin
      hi++;
      tick();
    end
    chk("t5_start_cycles", 32'(hi), 32'd15);
    expect_rsp(16'h0000, 4'd5, 1'b1);
    alu_done = 1'b1; alu_result = 16'h1234;
    tick();
    expect_rsp(16'h0000, 4'd5, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    chk("t5_late_done_rsp", 32'(rsp_valid), 32'd0);
    chk("t5_late_done_start", 32'(alu_start), 32'd0);
    chk("t5_late_done_busy", 32'(busy), 32'd0);
    alu_done = 1'b0;

    // 6: reset while in ISSUE aborts silently
    rsp0 = n_rsp;
    push(3'd1, 8'h40, 8'h02, 4'd6);
    wait_start(4);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_cmd_ready_rst", 32'(cmd_ready), 32'd0);
    chk("t6_alu_start", 32'(alu_start), 32'd0);
    chk("t6_alu_op", 32'(alu_op), 32'd0);
    chk("t6_alu_a", 32'(alu_a), 32'd0);
    chk("t6_alu_b", 32'(alu_b), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("t6_rsp_err", 32'(rsp_err), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    alu_done = 1'b1; alu_result = 16'h4242;
    rsp_ready = 1'b1;
    tick();
    alu_done = 1'b0;
    tick(); tick();
    chk("t6_no_response", 32'(n_rsp - rsp0), 32'd0);
    chk("t6_still_idle", 32'(busy), 32'd0);
    rsp_ready = 1'b0;
    push(3'd1, 8'h40, 8'h02, 4'd7);
    wait_start(4);
    do_alu(0, 3'd1, 8'h40, 8'h02, 16'h0042);
    expect_rsp(16'h0042, 4'd7, 1'b0);
    rsp_ready = 1'b1;
    tick();
    chk("t6_final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
